// File: rtl/mips32i_pkg.sv
// rtl/mips32i_pkg.sv - NPC control codes and 2-bit branch counter encodings
package mips32i_pkg;

  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_J   = 2'b01;
  localparam logic [1:0] NPC_BEQ = 2'b10;
  localparam logic [1:0] NPC_BNE = 2'b11;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && ctr != CTR_ST) nxt = ctr + 2'd1;
    else if (!taken && ctr != CTR_SNT) nxt = ctr - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/mips32i_btb.sv
// rtl/mips32i_btb.sv - direct-mapped BTB with 2-bit counters, one lookup and one train port
module mips32i_btb
  import mips32i_pkg::*;
#(
  parameter int         ENTRIES    = 16,
  parameter logic [1:0] CTR_INIT_T = 2'b10,
  parameter bit         PREDICT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lk_pc_i,
  output logic        lk_taken_o,
  output logic [31:0] lk_tgt_o,
  input  logic        tr_en_i,
  input  logic [31:0] tr_pc_i,
  input  logic        tr_taken_i,
  input  logic [31:0] tr_tgt_i
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx, tr_idx;
  logic [TAG_W-1:0] lk_tag, tr_tag;
  logic             lk_hit, tr_hit;

  assign lk_idx = lk_pc_i[IDX_W+1:2];
  assign lk_tag = lk_pc_i[31:IDX_W+2];
  assign tr_idx = tr_pc_i[IDX_W+1:2];
  assign tr_tag = tr_pc_i[31:IDX_W+2];

  // Training ignores PREDICT_EN so the table stays warm if prediction is re-enabled.
  assign lk_hit = PREDICT_EN && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign tr_hit = valid_q[tr_idx] && (tag_q[tr_idx] == tr_tag);

  assign lk_taken_o = lk_hit & ctr_q[lk_idx][1];
  assign lk_tgt_o   = tgt_q[lk_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (tr_en_i) begin
      if (tr_hit) begin
        ctr_q[tr_idx] <= ctr_step(ctr_q[tr_idx], tr_taken_i);
        if (tr_taken_i) tgt_q[tr_idx] <= tr_tgt_i;
      end else if (tr_taken_i) begin
        valid_q[tr_idx] <= 1'b1;
        tag_q[tr_idx]   <= tr_tag;
        tgt_q[tr_idx]   <= tr_tgt_i;
        ctr_q[tr_idx]   <= CTR_INIT_T;
      end
    end
  end

endmodule

// File: rtl/mips32i_pc_predict.sv
// rtl/mips32i_pc_predict.sv - fetch PC register with BTB prediction and EX-stage redirect
module mips32i_pc_predict
  import mips32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 16,
  parameter logic [1:0]  CTR_INIT_T  = 2'b10,
  parameter bit          PREDICT_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  output logic [31:0] fetch_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        res_valid,
  input  logic [31:0] res_pc,
  input  logic [1:0]  res_ctrl,
  input  logic        res_zero,
  input  logic [31:0] res_ext_imm,
  input  logic [25:0] res_j_imm,
  input  logic        res_pred_taken,
  input  logic [31:0] res_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] seq, br_tgt, j_tgt, btb_tgt;
  logic        taken, btb_taken;

  assign seq    = res_pc + 32'd4;
  assign br_tgt = seq + (res_ext_imm << 2);
  assign j_tgt  = {seq[31:28], res_j_imm, 2'b00};

  always_comb begin
    taken = 1'b0;
    case (res_ctrl)
      NPC_J:   taken = 1'b1;
      NPC_BEQ: taken = res_zero;
      NPC_BNE: taken = !res_zero;
      default: taken = 1'b0;
    endcase
  end

  assign redirect_pc = taken ? ((res_ctrl == NPC_J) ? j_tgt : br_tgt) : seq;
  // Only the target is compared: a taken prediction to the fall-through address is still correct.
  assign mispredict  = res_valid & !rst & (redirect_pc != res_pred_target);

  mips32i_btb #(
    .ENTRIES   (BTB_ENTRIES),
    .CTR_INIT_T(CTR_INIT_T),
    .PREDICT_EN(PREDICT_EN)
  ) u_btb (
    .clk       (clk),
    .rst       (rst),
    .lk_pc_i   (pc_q),
    .lk_taken_o(btb_taken),
    .lk_tgt_o  (btb_tgt),
    .tr_en_i   (res_valid & !rst & (res_ctrl != NPC_SEQ)),
    .tr_pc_i   (res_pc),
    .tr_taken_i(taken),
    .tr_tgt_i  (redirect_pc)
  );

  assign fetch_pc    = pc_q;
  assign pred_taken  = btb_taken;
  assign pred_target = btb_taken ? btb_tgt : pc_q + 32'd4;

  always_comb begin
    pc_d = pc_q;
    if (mispredict) pc_d = redirect_pc;
    else if (!stall) pc_d = pred_target;
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  logic unused_ok;
  assign unused_ok = res_pred_taken;

endmodule

// File: tb/tb_mips32i_pc_predict.sv
// tb/tb_mips32i_pc_predict.sv - scoreboard bench for the fetch PC predictor
module tb_mips32i_pc_predict;
  import mips32i_pkg::*;

  logic        clk = 1'b1;
  logic        rst, stall;
  logic [31:0] fetch_pc, pred_target, redirect_pc;
  logic        pred_taken, mispredict;
  logic        res_valid, res_zero, res_pred_taken;
  logic [31:0] res_pc, res_ext_imm, res_pred_target;
  logic [1:0]  res_ctrl;
  logic [25:0] res_j_imm;

  always #5 clk = ~clk;

  mips32i_pc_predict #(.RESET_PC(32'h400), .BTB_ENTRIES(16)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .fetch_pc(fetch_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .res_valid(res_valid), .res_pc(res_pc), .res_ctrl(res_ctrl), .res_zero(res_zero),
    .res_ext_imm(res_ext_imm), .res_j_imm(res_j_imm), .res_pred_taken(res_pred_taken),
    .res_pred_target(res_pred_target), .mispredict(mispredict), .redirect_pc(redirect_pc)
  );

  typedef struct packed {
    logic [4:0]  m;
    logic [31:0] fpc;
    logic        pt;
    logic [31:0] ptg;
    logic        mp;
    logic [31:0] rpc;
  } exp_t;

  localparam logic [4:0] M_ALL = 5'h1F;
  localparam logic [4:0] M_NOR = 5'h0F;

  exp_t  q_exp[$];
  string q_name[$];
  int    checks = 0;
  int    failures = 0;

  task automatic chk(string nm, string fld, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s.%s got=%h expected=%h", nm, fld, got, want);
    end
  endtask

  initial begin : monitor
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (q_exp.size() > 0) begin
        e  = q_exp.pop_front();
        nm = q_name.pop_front();
        if (e.m[0]) chk(nm, "fetch_pc", fetch_pc, e.fpc);
        if (e.m[1]) chk(nm, "pred_taken", {31'd0, pred_taken}, {31'd0, e.pt});
        if (e.m[2]) chk(nm, "pred_target", pred_target, e.ptg);
        if (e.m[3]) chk(nm, "mispredict", {31'd0, mispredict}, {31'd0, e.mp});
        if (e.m[4]) chk(nm, "redirect_pc", redirect_pc, e.rpc);
      end
    end
  end

  task automatic step(string nm, logic [4:0] m, logic [31:0] fpc, logic pt,
                      logic [31:0] ptg, logic mp, logic [31:0] rpc);
    exp_t e;
    e = '{m: m, fpc: fpc, pt: pt, ptg: ptg, mp: mp, rpc: rpc};
    q_exp.push_back(e);
    q_name.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic res_set(logic [1:0] ctrl, logic [31:0] pc, logic zero,
                         logic [31:0] ext, logic [25:0] jimm, logic [31:0] ptgt);
    res_valid = 1'b1; res_ctrl = ctrl; res_pc = pc; res_zero = zero;
    res_ext_imm = ext; res_j_imm = jimm; res_pred_target = ptgt;
    res_pred_taken = (ptgt != pc + 32'd4);
  endtask

  task automatic res_off();
    res_valid = 1'b0; res_ctrl = NPC_SEQ; res_pc = '0; res_zero = 1'b0;
    res_ext_imm = '0; res_j_imm = '0; res_pred_target = '0; res_pred_taken = 1'b0;
  endtask

  initial begin : driver
    rst = 1'b1; stall = 1'b0;
    res_set(NPC_SEQ, 32'h0, 1'b0, 32'h0, 26'h0, 32'h0);
    step("rst0", 5'b01000, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    step("rst1", M_ALL, 32'h400, 1'b0, 32'h404, 1'b0, 32'h4);
    rst = 1'b0; res_off();
    step("t1_a", M_NOR, 32'h400, 1'b0, 32'h404, 1'b0, 32'h0);
    step("t1_b", M_NOR, 32'h404, 1'b0, 32'h408, 1'b0, 32'h0);
    res_set(NPC_BEQ, 32'h400, 1'b1, 32'd3, 26'h0, 32'h404);
    step("t2_beq", M_ALL, 32'h408, 1'b0, 32'h40C, 1'b1, 32'h410);
    res_set(NPC_SEQ, 32'h3FC, 1'b0, 32'h0, 26'h0, 32'h0);
    step("t2_next", M_ALL, 32'h410, 1'b0, 32'h414, 1'b1, 32'h400);
    res_off();
    step("t3_hit", M_NOR, 32'h400, 1'b1, 32'h410, 1'b0, 32'h0);
    res_set(NPC_BNE, 32'h420, 1'b0, 32'd4, 26'h0, 32'h434);
    step("t4_alloc", M_ALL, 32'h410, 1'b0, 32'h414, 1'b0, 32'h434);
    res_set(NPC_SEQ, 32'h41C, 1'b0, 32'h0, 26'h0, 32'h0);
    step("t4_redir", M_ALL, 32'h414, 1'b0, 32'h418, 1'b1, 32'h420);
    res_set(NPC_BNE, 32'h420, 1'b1, 32'd4, 26'h0, 32'h434);
    step("t4_nt1", M_ALL, 32'h420, 1'b1, 32'h434, 1'b1, 32'h424);
    res_set(NPC_SEQ, 32'h41C, 1'b0, 32'h0, 26'h0, 32'h0);
    step("t4_redir2", M_ALL, 32'h424, 1'b0, 32'h428, 1'b1, 32'h420);
    res_set(NPC_BNE, 32'h420, 1'b1, 32'd4, 26'h0, 32'h424);
    step("t4_nt2", M_ALL, 32'h420, 1'b0, 32'h424, 1'b0, 32'h424);
    step("t4_nt3", M_ALL, 32'h424, 1'b0, 32'h428, 1'b0, 32'h424);
    res_set(NPC_SEQ, 32'h41C, 1'b0, 32'h0, 26'h0, 32'h0);
    step("t4_redir3", M_ALL, 32'h428, 1'b0, 32'h42C, 1'b1, 32'h420);
    res_set(NPC_SEQ, 32'h43C, 1'b0, 32'h0, 26'h0, 32'h0);
    step("t4_sat", M_ALL, 32'h420, 1'b0, 32'h424, 1'b1, 32'h440);
    stall = 1'b1;
    res_set(NPC_J, 32'h0FFF_FFF8, 1'b0, 32'h0, 26'h10, 32'h0FFF_FFFC);
    step("t5_j_stall", M_ALL, 32'h440, 1'b0, 32'h444, 1'b1, 32'h40);
    res_off();
    step("t6_alias", M_NOR, 32'h40, 1'b0, 32'h44, 1'b0, 32'h0);
    res_set(NPC_SEQ, 32'hFFFF_FFF8, 1'b0, 32'h0, 26'h0, 32'h0);
    step("t5_hold", M_ALL, 32'h40, 1'b0, 32'h44, 1'b1, 32'hFFFF_FFFC);
    stall = 1'b0; res_off();
    step("t6_wrap", M_NOR, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0);
    res_set(NPC_BEQ, 32'hFFFF_FFF8, 1'b1, 32'd1, 26'h0, 32'h0);
    step("t6_brwrap", M_ALL, 32'h0, 1'b0, 32'h4, 1'b0, 32'h0);
    rst = 1'b1;
    res_set(NPC_SEQ, 32'h3FC, 1'b0, 32'h0, 26'h0, 32'h0);
    step("rst_mid", M_ALL, 32'h4, 1'b0, 32'h8, 1'b0, 32'h400);
    rst = 1'b0; res_off();
    step("rst_mid_b", M_NOR, 32'h400, 1'b0, 32'h404, 1'b0, 32'h0);
    for (int i = 0; i < 10 && q_exp.size() > 0; i++) @(negedge clk);
    checks++;
    if (q_exp.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", q_exp.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog timeout reached");
    $fatal(1, "timeout");
  end

endmodule
